// File: rtl/addsub_mul_pkg.sv
// Shared constants for the add/subtract-then-multiply pipeline.
package addsub_mul_pkg;

  localparam logic OP_ADD        = 1'b1;
  localparam logic OP_SUB        = 1'b0;
  localparam int   DEFAULT_WIDTH = 8;

endpackage

// File: rtl/addsub_mul_stage.sv
// One pipeline stage: valid bit that advances with adv, plus a data register
// whose load enable is supplied by the parent.
module addsub_mul_stage
  import addsub_mul_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          load,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (adv) valid <= in_valid;
      if (load) data <= in_data;
    end
  end

endmodule

// File: rtl/addsub_mul_pipe.sv
// Three-stage pipeline computing (a +/- b) * c with overflow flag.
// Optional macro ADDSUB_MUL_CG_EN: data registers load only for valid data.
module addsub_mul_pipe
  import addsub_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic               s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] d,
  output logic               ovf
);

  localparam int OUT_W = 2 * WIDTH;
  localparam int SUM_W = WIDTH + 2;
  localparam int P_W   = 2 * WIDTH + 3;
  localparam int S1_W  = SUM_W + WIDTH;
  localparam int S3_W  = OUT_W + 1;

  // Handshake: a set transfers on an edge with in_valid && in_ready; a result
  // leaves on an edge with out_valid && out_ready. The whole pipe advances
  // together whenever the output register is empty or being drained.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             s1_valid, s2_valid, s3_valid;
  logic [S1_W-1:0]  s1_data;
  logic [P_W-1:0]   s2_data;
  logic [S3_W-1:0]  s3_data;
  logic             ld1, ld2, ld3;

`ifdef ADDSUB_MUL_CG_EN
  assign ld1 = adv & in_valid;
  assign ld2 = adv & s1_valid;
  assign ld3 = adv & s2_valid;
`else
  assign ld1 = adv;
  assign ld2 = adv;
  assign ld3 = adv;
`endif

  // Two extra bits hold the carry of a+b and the sign of a-b.
  logic [SUM_W-1:0] sum_c;
  always_comb begin
    sum_c = '0;
    if (s == OP_SUB) sum_c = {2'b00, a} - {2'b00, b};
    else             sum_c = {2'b00, a} + {2'b00, b};
  end

  addsub_mul_stage #(.DW(S1_W)) u_stage1 (
    .clk(clk), .rst(rst), .adv(adv), .load(ld1),
    .in_valid(in_valid), .in_data({sum_c, c}),
    .valid(s1_valid), .data(s1_data)
  );

  logic signed [P_W-1:0] sum_x, c_x, prod_c;
  assign sum_x  = P_W'($signed(s1_data[S1_W-1:WIDTH]));
  assign c_x    = P_W'({1'b0, s1_data[WIDTH-1:0]});
  assign prod_c = sum_x * c_x;

  addsub_mul_stage #(.DW(P_W)) u_stage2 (
    .clk(clk), .rst(rst), .adv(adv), .load(ld2),
    .in_valid(s1_valid), .in_data(prod_c),
    .valid(s2_valid), .data(s2_data)
  );

  // Exact product is out of range if negative or any bit above OUT_W is set.
  logic ovf_c;
  assign ovf_c = s2_data[P_W-1] | (|s2_data[P_W-2:OUT_W]);

  addsub_mul_stage #(.DW(S3_W)) u_stage3 (
    .clk(clk), .rst(rst), .adv(adv), .load(ld3),
    .in_valid(s2_valid), .in_data({ovf_c, s2_data[OUT_W-1:0]}),
    .valid(s3_valid), .data(s3_data)
  );

  assign out_valid = s3_valid;
  assign d         = s3_data[OUT_W-1:0];
  assign ovf       = s3_data[OUT_W];

endmodule

// File: tb/tb_addsub_mul_pipe.sv
// Self-checking bench for addsub_mul_pipe (WIDTH=8) with a queue-based model.
module tb_addsub_mul_pipe;

  localparam int W     = 8;
  localparam int OUT_W = 2 * W;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, b, c;
  logic             s;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] d;
  logic             ovf;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [OUT_W:0] exp_q[$];

  addsub_mul_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .s(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .ovf(ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce modulo 2^OUT_W.
  function automatic logic [OUT_W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [W-1:0] mc, input logic ms);
    longint r, m;
    logic   o;
    if (ms) r = (longint'(ma) + longint'(mb)) * longint'(mc);
    else    r = (longint'(ma) - longint'(mb)) * longint'(mc);
    o = (r < 0) || (r >= (longint'(1) << OUT_W));
    m = r % (longint'(1) << OUT_W);
    if (m < 0) m = m + (longint'(1) << OUT_W);
    return {o, m[OUT_W-1:0]};
  endfunction

  // scoreboard: record accepted sets, compare delivered results in order
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        check("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("result", 32'({ovf, d}), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c, s));
    end
  end

  // driver tasks
  task automatic drive_set(input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic [W-1:0] xc, input logic xs);
    a = xa; b = xb; c = xc; s = xs;
    in_valid = 1'b1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] xc, input logic xs,
                          input logic [OUT_W-1:0] ed, input logic eo);
    drive_set(xa, xb, xc, xs);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat0"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_d"}, 32'(d), 32'(ed));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  logic [W-1:0] sa[5], sb[5], sc[5];
  logic         ss[5];

  initial begin
    int n0, sent;
    logic held;
    logic [OUT_W-1:0] hold_d;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; s = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    directed("add", 8'd3, 8'd4, 8'd5, 1'b1, 16'd35, 1'b0);
    directed("sub", 8'd10, 8'd3, 8'd7, 1'b0, 16'd49, 1'b0);
    directed("neg", 8'd2, 8'd5, 8'd3, 1'b0, 16'd65527, 1'b1);
    directed("max", 8'd255, 8'd255, 8'd255, 1'b1, 16'd64514, 1'b1);
    directed("zero", 8'd0, 8'd255, 8'd0, 1'b0, 16'd0, 1'b0);

    directed("hold", 8'd3, 8'd4, 8'd5, 1'b1, 16'd35, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
`ifdef ADDSUB_MUL_CG_EN
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_d_held", 32'(d), 32'd35);
`endif
    end

    // back-to-back random burst
    n0 = n_out;
    for (int i = 0; i < 200; i++) begin
      drive_set(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("burst_count", 32'(n_out - n0), 32'd200);

    // stall with output back-pressure in cycles 4..9
    for (int i = 0; i < 5; i++) begin
      sa[i] = 8'($urandom_range(255, 0)); sb[i] = 8'($urandom_range(255, 0));
      sc[i] = 8'($urandom_range(255, 0)); ss[i] = 1'($urandom_range(1, 0));
    end
    n0 = n_out; sent = 0; held = 1'b0; hold_d = '0;
    for (int k = 0; k < 30; k++) begin
      out_ready = !(k >= 4 && k <= 9);
      if (sent < 5) drive_set(sa[sent], sb[sent], sc[sent], ss[sent]);
      else in_valid = 1'b0;
      #3;
      if (in_valid && in_ready) sent++;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (held) check("stall_d_hold", 32'(d), 32'(hold_d));
        held = 1'b1;
        hold_d = d;
      end else begin
        held = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_sent", 32'(sent), 32'd5);
    check("stall_delivered", 32'(n_out - n0), 32'd5);

    // reset with three sets in flight and a competing handshake
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_set(8'(i + 1), 8'd2, 8'd3, 1'b1);
      @(posedge clk); #1;
    end
    drive_set(8'd9, 8'd9, 8'd9, 1'b1);
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_d", 32'(d), 32'd0);
    check("rst2_ovf", 32'(ovf), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 check("rst2_no_ghost", 32'(out_valid), 32'd0);
    directed("post_rst", 8'd1, 8'd1, 8'd1, 1'b1, 16'd2, 1'b0);

    repeat (5) @(posedge clk);
    #1 check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
